ising_axi_bridge: RTL and testbench

ISING_AXI_BRIDGE -- requirements
Module: ising_axi_bridge

---
 rtl/ising_axi_bridge.sv | 195 +++++++++++++++++++
 tb/tb_ising_axi_bridge.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_axi_bridge.sv
// AXI4-Lite slave bridge onto the Ising register block: the write and read paths are
// separate, independent FSMs. Each path allows one outstanding transaction.
module ising_axi_bridge #(
  parameter int RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        axi_rst,
  // write address / data / response
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  // read address / data
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  // register block side
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_wdata,
  output logic        arvalid_q,
  output logic [31:0] araddr_q,
  input  logic        rvalid_in,
  input  logic        rresp_in,
  input  logic [31:0] rdata_in,
  output logic        rready_out,
  // FSM state observation
  output logic [1:0]  w_state_dbg,
  output logic [1:0]  r_state_dbg
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both high; valid and its payload stay stable until then.

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ISSUE = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3} r_state_t;

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

  w_state_t       w_state;
  r_state_t       r_state;
  logic           aw_done;
  logic           w_done;
  logic [31:0]    aw_addr;
  logic [31:0]    w_data;
  logic [3:0]     w_strb;
  logic [CW-1:0]  wait_cnt;

  logic           aw_hit;
  logic           w_hit;
  logic [31:0]    addr_nxt;
  logic [31:0]    data_nxt;
  logic [3:0]     strb_nxt;

  // Readies depend only on state, and are held low while reset is applied.
  assign s_awready  = !axi_rst && (w_state == W_IDLE) && !aw_done;
  assign s_wready   = !axi_rst && (w_state == W_IDLE) && !w_done;
  assign s_arready  = !axi_rst && (r_state == R_IDLE);
  assign rready_out = (r_state == R_WAIT) && rvalid_in;

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  // A channel counts as captured if it was taken earlier or is being taken this cycle.
  always_comb begin
    aw_hit   = aw_done || s_awvalid;
    w_hit    = w_done || s_wvalid;
    addr_nxt = aw_done ? aw_addr : s_awaddr;
    data_nxt = w_done ? w_data : s_wdata;
    strb_nxt = w_done ? w_strb : s_wstrb;
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      w_state  <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_wdata <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_awvalid && !aw_done) begin
            aw_done <= 1'b1;
            aw_addr <= s_awaddr;
          end
          if (s_wvalid && !w_done) begin
            w_done <= 1'b1;
            w_data <= s_wdata;
            w_strb <= s_wstrb;
          end
          if (aw_hit && w_hit) begin
            w_state <= W_ISSUE;
            // Partial-strobe writes are refused rather than read-modify-written.
            if (strb_nxt == 4'hF) begin
              wr_en    <= 1'b1;
              wr_addr  <= addr_nxt;
              wr_wdata <= data_nxt;
            end
          end
        end
        W_ISSUE: begin
          wr_en    <= 1'b0;
          wr_addr  <= '0;
          wr_wdata <= '0;
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          s_bvalid <= 1'b1;
          s_bresp  <= (w_strb == 4'hF) ? 2'b00 : 2'b10;
          w_state  <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_state   <= R_IDLE;
      wait_cnt  <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid) begin
            arvalid_q <= 1'b1;
            araddr_q  <= s_araddr;
            r_state   <= R_REQ;
          end
        end
        R_REQ: begin
          arvalid_q <= 1'b0;
          araddr_q  <= '0;
          wait_cnt  <= '0;
          r_state   <= R_WAIT;
        end
        R_WAIT: begin
          // Data arriving on the last allowed wait cycle still wins over the timeout.
          if (rvalid_in) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rdata_in;
            s_rresp  <= {rresp_in, 1'b0};
            r_state  <= R_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            s_rvalid <= 1'b1;
            s_rdata  <= 32'hDEADBEEF;
            s_rresp  <= 2'b10;
            r_state  <= R_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= 2'b00;
            wait_cnt <= '0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ising_axi_bridge.sv
// Bench for ising_axi_bridge: directed scenarios plus randomized transactions checked
// against transaction-level expectations (latencies, responses, timeout window).
module tb_ising_axi_bridge;
  localparam int RD_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        axi_rst;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        wr_en;
  logic [31:0] wr_addr, wr_wdata;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic        rvalid_in, rresp_in;
  logic [31:0] rdata_in;
  logic        rready_out;
  logic [1:0]  w_state_dbg, r_state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];

  ising_axi_bridge #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .axi_rst(axi_rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_wdata(wr_wdata),
    .arvalid_q(arvalid_q), .araddr_q(araddr_q),
    .rvalid_in(rvalid_in), .rresp_in(rresp_in), .rdata_in(rdata_in), .rready_out(rready_out),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [139:0] all_outs();
    return {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
            wr_en, wr_addr, wr_wdata, arvalid_q, araddr_q, rready_out};
  endfunction

  // driver tasks
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_start, input int w_start, input int bdelay);
    bit aw_hs, w_hs, done, good;
    int hs_cyc, wr_cnt, bv_cnt;
    logic [1:0] exp_resp;
    aw_hs = 0; w_hs = 0; done = 0; hs_cyc = -1; wr_cnt = 0; bv_cnt = 0;
    good = (strb == 4'hF);
    exp_resp = good ? 2'b00 : 2'b10;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      s_awvalid = !aw_hs && (cyc >= aw_start);
      s_awaddr  = addr;
      s_wvalid  = !w_hs && (cyc >= w_start);
      s_wdata   = data;
      s_wstrb   = strb;
      s_bready  = (bv_cnt >= bdelay);
      #1;
      if (wr_en) begin
        wr_cnt++;
        n_vec++;
        if (!good || hs_cyc < 0 || cyc != hs_cyc + 1 || wr_addr !== addr || wr_wdata !== data) begin
          n_err++;
          $display("FAIL wr_strobe: cyc %0d addr %h data %h, expected cyc %0d addr %h data %h allowed %0d",
                   cyc, wr_addr, wr_wdata, hs_cyc + 1, addr, data, good);
        end
      end
      if (hs_cyc >= 0 && cyc == hs_cyc + 2) begin
        n_vec++;
        if (s_bvalid !== 1'b1) begin
          n_err++;
          $display("FAIL bvalid_latency: bvalid %b at handshake+2, expected 1", s_bvalid);
        end
      end
      if (s_bvalid) begin
        n_vec++;
        if (s_bresp !== exp_resp) begin
          n_err++;
          $display("FAIL bresp: got %b expected %b", s_bresp, exp_resp);
        end
        bv_cnt++;
        if (s_bready) done = 1;
      end else if (bv_cnt > 0) begin
        n_vec++;
        n_err++;
        $display("FAIL bvalid_hold: bvalid dropped to 0 before bready, expected 1");
      end
      if (s_awvalid && s_awready) aw_hs = 1;
      if (s_wvalid && s_wready) w_hs = 1;
      if (aw_hs && w_hs && hs_cyc < 0) hs_cyc = cyc;
      cycle();
    end
    s_awvalid = 0; s_wvalid = 0; s_bready = 0;
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL write_timeout: no B handshake for addr %h, expected one", addr);
    end
    n_vec++;
    if (wr_cnt != (good ? 1 : 0) || bv_cnt != bdelay + 1) begin
      n_err++;
      $display("FAIL write_counts: wr_en pulses %0d bvalid cycles %0d, expected %0d and %0d",
               wr_cnt, bv_cnt, good ? 1 : 0, bdelay + 1);
    end
    n_vec++;
    if (s_bvalid !== 1'b0 || s_awready !== 1'b1 || s_wready !== 1'b1) begin
      n_err++;
      $display("FAIL write_idle: bvalid %b awready %b wready %b, expected 0 1 1", s_bvalid, s_awready, s_wready);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int delay, input logic rresp_bit,
                         input logic [31:0] data, input int rdelay);
    bit ar_hs, done, accepted;
    int ar_cyc, arq_cyc, arq_cnt, rr_cnt, rv_cnt, exp_first;
    ar_hs = 0; done = 0; ar_cyc = -1; arq_cyc = -1; arq_cnt = 0; rr_cnt = 0; rv_cnt = 0;
    accepted = (delay >= 1) && (delay <= RD_TIMEOUT);
    exp_q.push_back(accepted ? {rresp_bit, 1'b0, data} : {2'b10, 32'hDEADBEEF});
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      s_arvalid = !ar_hs;
      s_araddr  = addr;
      s_rready  = (rv_cnt >= rdelay);
      rvalid_in = 0;
      #1;
      if (arvalid_q) begin
        arq_cnt++;
        n_vec++;
        if (ar_cyc < 0 || cyc != ar_cyc + 1 || araddr_q !== addr) begin
          n_err++;
          $display("FAIL arvalid_q: cyc %0d araddr_q %h, expected cyc %0d addr %h", cyc, araddr_q, ar_cyc + 1, addr);
        end
        arq_cyc = cyc;
      end
      rvalid_in = (arq_cyc >= 0) && (cyc == arq_cyc + delay);
      rdata_in  = rvalid_in ? data : $urandom;
      rresp_in  = rresp_bit;
      #1;
      if (rready_out) begin
        rr_cnt++;
        n_vec++;
        if (!accepted || cyc != arq_cyc + delay) begin
          n_err++;
          $display("FAIL rready_out: pulse at cyc %0d, expected cyc %0d accepted %0d", cyc, arq_cyc + delay, accepted);
        end
      end
      if (s_rvalid) begin
        if (rv_cnt == 0) begin
          exp_first = arq_cyc + (accepted ? delay + 1 : RD_TIMEOUT + 1);
          n_vec++;
          if (cyc != exp_first) begin
            n_err++;
            $display("FAIL rvalid_latency: first rvalid cyc %0d, expected %0d", cyc, exp_first);
          end
        end
        n_vec++;
        if ({s_rresp, s_rdata} !== exp_q[0]) begin
          n_err++;
          $display("FAIL rdata: got %h expected %h", {s_rresp, s_rdata}, exp_q[0]);
        end
        rv_cnt++;
        if (s_rready) done = 1;
      end else if (rv_cnt > 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rvalid_hold: rvalid dropped before rready, expected 1");
      end
      if (s_arvalid && s_arready) begin
        ar_hs = 1;
        ar_cyc = cyc;
      end
      cycle();
    end
    s_arvalid = 0; s_rready = 0; rvalid_in = 0;
    void'(exp_q.pop_front());
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL read_timeout: no R handshake for addr %h, expected one", addr);
    end
    n_vec++;
    if (arq_cnt != 1 || rr_cnt != (accepted ? 1 : 0)) begin
      n_err++;
      $display("FAIL read_counts: arvalid_q %0d rready_out %0d, expected 1 and %0d", arq_cnt, rr_cnt, accepted ? 1 : 0);
    end
    n_vec++;
    if (s_rvalid !== 1'b0 || s_rdata !== 32'h0 || s_arready !== 1'b1) begin
      n_err++;
      $display("FAIL read_idle: rvalid %b rdata %h arready %b, expected 0 0 1", s_rvalid, s_rdata, s_arready);
    end
  endtask

  // scenarios
  task automatic test_reset();
    axi_rst = 1;
    repeat (2) cycle();
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    axi_rst = 0;
    #1;
    n_vec++;
    if ({s_awready, s_wready, s_arready} !== 3'b111 || s_bvalid !== 0 || s_rvalid !== 0 || wr_en !== 0) begin
      n_err++;
      $display("FAIL reset_release: readies %b bvalid %b rvalid %b wr_en %b, expected 111 0 0 0",
               {s_awready, s_wready, s_arready}, s_bvalid, s_rvalid, wr_en);
    end
    cycle();
  endtask

  task automatic test_write_basic();
    do_write(32'h600, 32'h0000_00FF, 4'hF, 0, 0, 5);
    do_write(32'h1000, 32'h1234_5678, 4'h3, 3, 0, 0);
    do_write(32'h1004, 32'hCAFE_F00D, 4'hF, 0, 2, 1);
  endtask

  task automatic test_read_basic();
    do_read(32'h820, 2, 1'b0, 32'h1, 0);
    do_read(32'h824, 100, 1'b0, 32'h5555, 0);
    do_read(32'h828, RD_TIMEOUT, 1'b1, 32'hA5A5_0001, 2);
    do_read(32'h82C, RD_TIMEOUT + 1, 1'b0, 32'h77, 0);
    do_read(32'h830, 0, 1'b0, 32'h99, 1);
  endtask

  task automatic test_concurrent();
    s_awvalid = 1; s_awaddr = 32'h500; s_wvalid = 1; s_wdata = 32'h0BAD_CAFE; s_wstrb = 4'hF;
    s_arvalid = 1; s_araddr = 32'h800;
    #1;
    n_vec++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) begin
      n_err++;
      $display("FAIL conc_ready: readies %b expected 111", {s_awready, s_wready, s_arready});
    end
    cycle();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    n_vec++;
    if (wr_en !== 1 || wr_addr !== 32'h500 || arvalid_q !== 1 || araddr_q !== 32'h800) begin
      n_err++;
      $display("FAIL conc_issue: wr_en %b wr_addr %h arvalid_q %b araddr_q %h, expected 1 500 1 800",
               wr_en, wr_addr, arvalid_q, araddr_q);
    end
    cycle();
    s_bready = 1; rvalid_in = 1; rdata_in = 32'h0000_ABCD; rresp_in = 0;
    #1;
    n_vec++;
    if (s_bvalid !== 1 || s_bresp !== 2'b00 || rready_out !== 1) begin
      n_err++;
      $display("FAIL conc_resp: bvalid %b bresp %b rready_out %b, expected 1 00 1", s_bvalid, s_bresp, rready_out);
    end
    cycle();
    s_bready = 0; rvalid_in = 0; s_rready = 1;
    n_vec++;
    if (s_bvalid !== 0 || s_rvalid !== 1 || s_rdata !== 32'h0000_ABCD || s_rresp !== 2'b00) begin
      n_err++;
      $display("FAIL conc_rdata: bvalid %b rvalid %b rdata %h rresp %b, expected 0 1 0000abcd 00",
               s_bvalid, s_rvalid, s_rdata, s_rresp);
    end
    cycle();
    s_rready = 0;
    n_vec++;
    if (s_rvalid !== 0 || s_rdata !== 0) begin
      n_err++;
      $display("FAIL conc_done: rvalid %b rdata %h, expected 0 0", s_rvalid, s_rdata);
    end
  endtask

  task automatic test_reset_mid();
    s_awvalid = 1; s_awaddr = 32'h700; s_wvalid = 1; s_wdata = 32'h1111; s_wstrb = 4'hF;
    s_arvalid = 1; s_araddr = 32'h900;
    cycle();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    repeat (2) cycle();
    n_vec++;
    if (s_bvalid !== 1 || s_rvalid !== 0) begin
      n_err++;
      $display("FAIL midrst_setup: bvalid %b rvalid %b, expected 1 0", s_bvalid, s_rvalid);
    end
    #2 axi_rst = 1;
    #1;
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL midrst_async: got %h expected 0", all_outs());
    end
    repeat (2) cycle();
    axi_rst = 0;
    s_bready = 1; s_rready = 1;
    for (int i = 0; i < 24; i++) begin
      rvalid_in = 1'($urandom_range(0, 1));
      rdata_in = $urandom;
      #1;
      n_vec++;
      if ({s_bvalid, s_rvalid, wr_en, arvalid_q, rready_out} !== 5'b0 ||
          {s_awready, s_wready, s_arready} !== 3'b111) begin
        n_err++;
        $display("FAIL midrst_quiet: cyc %0d b/r/wr/arq/rr %b readies %b, expected 00000 111",
                 i, {s_bvalid, s_rvalid, wr_en, arvalid_q, rready_out}, {s_awready, s_wready, s_arready});
      end
      cycle();
    end
    rvalid_in = 0; s_bready = 0; s_rready = 0;
    do_write(32'h704, 32'h2222, 4'hF, 0, 0, 0);
    do_read(32'h904, 3, 1'b0, 32'h3333, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_write($urandom, $urandom, ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      do_read($urandom, $urandom_range(0, RD_TIMEOUT + 3), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3));
    end
  endtask

  initial begin
    axi_rst = 1;
    s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_rready = 0;
    rvalid_in = 0; rresp_in = 0; rdata_in = 0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
